// File: rtl/aap_pkg.sv
// Shared AAP pipeline definitions used by the execute stage and its data memory.
package aap_pkg;
  localparam int DATA_MEM_ADDR_W = 9;
  localparam int DATA_MEM_DATA_W = 32;
  localparam int DATA_MEM_DEPTH  = 512;

  typedef logic [DATA_MEM_DATA_W-1:0] data_word_t;
  typedef logic [DATA_MEM_ADDR_W-1:0] data_addr_t;
endpackage

// File: rtl/data_mem_wr_arbiter.sv
// Write-port collision filter: a port's enable is dropped when any higher-numbered
// enabled port targets the same address, so the surviving writes never overlap.
module data_mem_wr_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int ADDR_W    = 9
) (
  input  logic [NUM_PORTS-1:0]             wr_en,
  input  logic [NUM_PORTS-1:0][ADDR_W-1:0] wr_addr,
  output logic [NUM_PORTS-1:0]             wr_en_eff
);
  always_comb begin
    wr_en_eff = wr_en;
    for (int i = 0; i < NUM_PORTS; i++)
      for (int j = i + 1; j < NUM_PORTS; j++)
        if (wr_en[j] && (wr_addr[j] == wr_addr[i])) wr_en_eff[i] = 1'b0;
  end
endmodule

// File: rtl/data_memory_4r4w.sv
// 512x32 data memory: four combinational read ports, four clocked write ports
// with highest-port-wins collision resolution and a synchronous full clear.
module data_memory_4r4w
  import aap_pkg::*;
#(
  parameter int ADDR_W = DATA_MEM_ADDR_W,
  parameter int DATA_W = DATA_MEM_DATA_W,
  parameter int DEPTH  = DATA_MEM_DEPTH
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] data_rd1,
  input  logic [ADDR_W-1:0] data_rd2,
  input  logic [ADDR_W-1:0] data_rd3,
  input  logic [ADDR_W-1:0] data_rd4,
  input  logic [ADDR_W-1:0] data_wr1,
  input  logic [ADDR_W-1:0] data_wr2,
  input  logic [ADDR_W-1:0] data_wr3,
  input  logic [ADDR_W-1:0] data_wr4,
  input  logic [DATA_W-1:0] data_wr1_data,
  input  logic [DATA_W-1:0] data_wr2_data,
  input  logic [DATA_W-1:0] data_wr3_data,
  input  logic [DATA_W-1:0] data_wr4_data,
  input  logic              data_wr1_enable,
  input  logic              data_wr2_enable,
  input  logic              data_wr3_enable,
  input  logic              data_wr4_enable,
  output logic [DATA_W-1:0] data_rd1_out,
  output logic [DATA_W-1:0] data_rd2_out,
  output logic [DATA_W-1:0] data_rd3_out,
  output logic [DATA_W-1:0] data_rd4_out
);
  localparam int NUM_PORTS = 4;

  logic [DATA_W-1:0]               mem [DEPTH];
  logic [NUM_PORTS-1:0]             wr_en, wr_en_eff;
  logic [NUM_PORTS-1:0][ADDR_W-1:0] wr_addr;
  logic [NUM_PORTS-1:0][DATA_W-1:0] wr_data;

  assign wr_en   = {data_wr4_enable, data_wr3_enable, data_wr2_enable, data_wr1_enable};
  assign wr_addr = {data_wr4, data_wr3, data_wr2, data_wr1};
  assign wr_data = {data_wr4_data, data_wr3_data, data_wr2_data, data_wr1_data};

  data_mem_wr_arbiter #(.NUM_PORTS(NUM_PORTS), .ADDR_W(ADDR_W)) u_arb (
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_en_eff (wr_en_eff)
  );

  // Masked enables never share an address, so application order is irrelevant.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++)
        if (wr_en_eff[p]) mem[wr_addr[p]] <= wr_data[p];
    end
  end

  assign data_rd1_out = mem[data_rd1];
  assign data_rd2_out = mem[data_rd2];
  assign data_rd3_out = mem[data_rd3];
  assign data_rd4_out = mem[data_rd4];
endmodule

// File: tb/tb_data_memory_4r4w.sv
// Bench for data_memory_4r4w: array model updated by in-order port writes, checked
// every negedge, plus directed literal checks of reset, priority and read-during-write.
module tb_data_memory_4r4w;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [8:0]  rd [4];
  logic [8:0]  wa [4];
  logic [31:0] wd [4];
  logic        we [4];
  logic [31:0] ro [4];

  int tests = 0;
  int fails = 0;

  logic [31:0] mem_m [512];
  logic        model_ok = 1'b0;

  always #5 clock = ~clock;

  data_memory_4r4w dut (
    .clock           (clock),
    .reset           (reset),
    .data_rd1        (rd[0]),
    .data_rd2        (rd[1]),
    .data_rd3        (rd[2]),
    .data_rd4        (rd[3]),
    .data_wr1        (wa[0]),
    .data_wr2        (wa[1]),
    .data_wr3        (wa[2]),
    .data_wr4        (wa[3]),
    .data_wr1_data   (wd[0]),
    .data_wr2_data   (wd[1]),
    .data_wr3_data   (wd[2]),
    .data_wr4_data   (wd[3]),
    .data_wr1_enable (we[0]),
    .data_wr2_enable (we[1]),
    .data_wr3_enable (we[2]),
    .data_wr4_enable (we[3]),
    .data_rd1_out    (ro[0]),
    .data_rd2_out    (ro[1]),
    .data_rd3_out    (ro[2]),
    .data_rd4_out    (ro[3])
  );

  // Model: writes applied port 1 first, port 4 last, so the later port simply overwrites.
  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 512; i++) mem_m[i] <= 32'h0;
      model_ok <= 1'b1;
    end else begin
      for (int p = 0; p < 4; p++)
        if (we[p]) mem_m[wa[p]] <= wd[p];
    end
  end

  always @(negedge clock) begin
    if (model_ok) begin
      for (int p = 0; p < 4; p++) begin
        tests++;
        if (ro[p] !== mem_m[rd[p]]) begin
          fails++;
          $display("FAIL model_rd%0d addr=%0d got=%h exp=%h", p + 1, rd[p], ro[p], mem_m[rd[p]]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clr_wr();
    for (int p = 0; p < 4; p++) begin
      we[p] = 1'b0; wa[p] = '0; wd[p] = '0;
    end
  endtask

  task automatic set_wr(input int p, input logic [8:0] a, input logic [31:0] d);
    we[p] = 1'b1; wa[p] = a; wd[p] = d;
  endtask

  task automatic set_rd_all(input logic [8:0] a);
    for (int p = 0; p < 4; p++) rd[p] = a;
  endtask

  initial begin
    clr_wr();
    set_rd_all(9'd0);
    #1;
    reset = 1'b1; tick(); reset = 1'b0;

    // 1: write then reset clears
    set_wr(0, 9'd7, 32'h12345678); tick(); clr_wr();
    rd[0] = 9'd7; #1;
    check("pre_reset_addr7", ro[0], 32'h12345678);
    reset = 1'b1; tick(); reset = 1'b0;
    set_rd_all(9'd7); #1;
    for (int p = 0; p < 4; p++) check($sformatf("reset_addr7_rd%0d", p + 1), ro[p], 32'h0);
    set_rd_all(9'd0); #1;
    for (int p = 0; p < 4; p++) check($sformatf("reset_addr0_rd%0d", p + 1), ro[p], 32'h0);

    // 2: single write on port 2
    rd[2] = 9'd5;
    set_wr(1, 9'd5, 32'hDEADBEEF); #1;
    check("single_before_edge", ro[2], 32'h0);
    tick(); clr_wr();
    check("single_after_edge", ro[2], 32'hDEADBEEF);
    tick(); tick();
    check("single_held", ro[2], 32'hDEADBEEF);

    // 3: parallel writes
    set_wr(0, 9'd1, 32'h11111111); set_wr(1, 9'd2, 32'h22222222);
    set_wr(2, 9'd3, 32'h33333333); set_wr(3, 9'd4, 32'h44444444);
    for (int p = 0; p < 4; p++) rd[p] = 9'(p + 1);
    tick(); clr_wr();
    check("par_rd1", ro[0], 32'h11111111);
    check("par_rd2", ro[1], 32'h22222222);
    check("par_rd3", ro[2], 32'h33333333);
    check("par_rd4", ro[3], 32'h44444444);

    // 4: collisions
    set_rd_all(9'd10);
    set_wr(0, 9'd10, 32'hAAAA0000); set_wr(3, 9'd10, 32'h0000BBBB);
    tick(); clr_wr();
    check("coll_p1_p4", ro[0], 32'h0000BBBB);
    set_wr(0, 9'd10, 32'h00001234); set_wr(1, 9'd10, 32'h5678ABCD);
    tick(); clr_wr();
    check("coll_p1_p2", ro[1], 32'h5678ABCD);
    rd[3] = 9'd12; rd[2] = 9'd13;
    set_wr(0, 9'd12, 32'h1); set_wr(1, 9'd12, 32'h2); set_wr(2, 9'd12, 32'h3);
    set_wr(3, 9'd13, 32'h4);
    tick(); clr_wr();
    check("coll_p1_p2_p3", ro[3], 32'h3);
    check("coll_other_addr", ro[2], 32'h4);

    // 5: read-during-write at top address
    reset = 1'b1; tick(); reset = 1'b0;
    rd[0] = 9'd511;
    set_wr(2, 9'd511, 32'hCAFEF00D); #1;
    check("rdw_before_edge", ro[0], 32'h0);
    tick(); clr_wr();
    check("rdw_after_edge", ro[0], 32'hCAFEF00D);

    // 6: reset beats write; disabled port has no effect
    set_wr(0, 9'd20, 32'h00000077); tick(); clr_wr();
    rd[1] = 9'd20; #1;
    check("pre_addr20", ro[1], 32'h00000077);
    reset = 1'b1; set_wr(0, 9'd20, 32'hFFFFFFFF);
    tick(); reset = 1'b0; clr_wr();
    check("reset_over_write", ro[1], 32'h0);
    wa[1] = 9'd20; wd[1] = 32'h5; we[1] = 1'b0;
    tick(); clr_wr();
    check("disabled_port", ro[1], 32'h0);

    // Mixed traffic on a small address window to provoke collisions; model checks it.
    for (int c = 0; c < 40; c++) begin
      for (int p = 0; p < 4; p++) begin
        we[p] = 1'($urandom_range(0, 1));
        wa[p] = 9'($urandom_range(0, 7));
        wd[p] = $urandom;
        rd[p] = 9'($urandom_range(0, 7));
      end
      tick();
    end
    clr_wr();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
